// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Miss-side refill sequencer for a 4-way set-associative cache.
//            Takes the victim way chosen by the LRU selector, writes back the
//            victim line word by word if it is dirty, then fetches the new
//            line from memory, writes it into the victim way and finally
//            updates that way's tag entry (valid=1, dirty=0).
// Ports    :
//   clk, rst                     clock / asynchronous active-high reset
//   miss_req, miss_index,        miss request (level) and its set/tag
//   miss_tag
//   replaced_way                 victim way 0..3, 4 = no replacement
//   victim_dirty, victim_tag     state of the victim way at miss_index
//   line_rd_en, line_rd_word,    victim read port into the data array
//   line_rd_data                 (read data one cycle after the strobe)
//   mem_req, mem_we, mem_addr,   memory-side bus; a transfer completes in
//   mem_wdata, mem_ack,          the cycle mem_req && mem_ack
//   mem_rdata
//   fill_we, fill_way,           data-array write port for fetched words
//   fill_index, fill_word,
//   fill_data
//   tag_we, tag_value            tag-array update strobe and new tag
//   busy, done                   status: not idle / refill complete pulse
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int WAY_NUM        = 4,
    parameter int INDEX_WIDTH    = 6,
    parameter int TAG_WIDTH      = 22,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = TAG_WIDTH + INDEX_WIDTH + $clog2(WORDS_PER_LINE) + 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_req,
    input  logic [INDEX_WIDTH-1:0]            miss_index,
    input  logic [TAG_WIDTH-1:0]              miss_tag,
    input  logic [2:0]                        replaced_way,
    input  logic                              victim_dirty,
    input  logic [TAG_WIDTH-1:0]              victim_tag,
    output logic                              line_rd_en,
    output logic [$clog2(WORDS_PER_LINE)-1:0] line_rd_word,
    input  logic [DATA_WIDTH-1:0]             line_rd_data,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_ack,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              fill_we,
    output logic [1:0]                        fill_way,
    output logic [INDEX_WIDTH-1:0]            fill_index,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
    output logic [DATA_WIDTH-1:0]             fill_data,
    output logic                              tag_we,
    output logic [TAG_WIDTH-1:0]              tag_value,
    output logic                              busy,
    output logic                              done
);

    localparam int c_WORD_W = $clog2(WORDS_PER_LINE);
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(WORDS_PER_LINE - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WB_RD   = 3'd1;
    localparam logic [2:0] c_ST_WB_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WB_REQ  = 3'd3;
    localparam logic [2:0] c_ST_FILL    = 3'd4;
    localparam logic [2:0] c_ST_TAG     = 3'd5;

    // Reject unsupported configurations at elaboration time.
    generate
        if (WAY_NUM != 4 || WORDS_PER_LINE < 2 ||
            (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0) begin : g_param_check
            $error("cache_refill_ctrl: WAY_NUM must be 4 and WORDS_PER_LINE a power of 2 >= 2");
        end
    endgenerate

    logic [2:0]             r_state;
    logic [c_WORD_W-1:0]    r_cnt;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [TAG_WIDTH-1:0]   r_vtag;
    logic [1:0]             r_way;
    logic [DATA_WIDTH-1:0]  r_wdata;

    logic                   w_last;

    assign w_last = (r_cnt == c_LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_index <= '0;
            r_tag   <= '0;
            r_vtag  <= '0;
            r_way   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // replaced_way==4 means the selector found nothing to
                    // replace; such a request is simply not accepted.
                    if (miss_req && (replaced_way < 3'd4)) begin
                        r_index <= miss_index;
                        r_tag   <= miss_tag;
                        r_vtag  <= victim_tag;
                        r_way   <= replaced_way[1:0];
                        r_cnt   <= '0;
                        r_state <= victim_dirty ? c_ST_WB_RD : c_ST_FILL;
                    end
                end
                c_ST_WB_RD: begin
                    r_state <= c_ST_WB_WAIT;
                end
                c_ST_WB_WAIT: begin
                    // Data array returns the victim word one cycle after
                    // the read strobe; hold it for the whole bus write.
                    r_wdata <= line_rd_data;
                    r_state <= c_ST_WB_REQ;
                end
                c_ST_WB_REQ: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_FILL;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= c_ST_WB_RD;
                        end
                    end
                end
                c_ST_FILL: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_TAG;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_TAG: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registered state, so an asynchronous reset
    // drives every one of them to zero immediately. Data/address fields are
    // zeroed whenever their strobe is inactive.
    always_comb begin
        line_rd_en   = 1'b0;
        line_rd_word = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_we      = 1'b0;
        fill_way     = '0;
        fill_index   = '0;
        fill_word    = '0;
        fill_data    = '0;
        tag_we       = 1'b0;
        tag_value    = '0;
        busy         = (r_state != c_ST_IDLE);
        done         = 1'b0;

        case (r_state)
            c_ST_WB_RD: begin
                line_rd_en   = 1'b1;
                line_rd_word = r_cnt;
            end
            c_ST_WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_vtag, r_index, r_cnt, 2'b00};
                mem_wdata = r_wdata;
            end
            c_ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_index, r_cnt, 2'b00};
                // Fetched word goes straight into the array in the ack cycle.
                if (mem_ack) begin
                    fill_we    = 1'b1;
                    fill_way   = r_way;
                    fill_index = r_index;
                    fill_word  = r_cnt;
                    fill_data  = mem_rdata;
                end
            end
            c_ST_TAG: begin
                tag_we    = 1'b1;
                tag_value = r_tag;
                done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Directed self-checking bench for cache_refill_ctrl. Models a
//            registered data-array read port and a memory with a
//            programmable number of wait cycles per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [5:0]  miss_index = '0;
    logic [21:0] miss_tag = '0;
    logic [2:0]  replaced_way = '0;
    logic        victim_dirty = 1'b0;
    logic [21:0] victim_tag = '0;
    logic        line_rd_en;
    logic [1:0]  line_rd_word;
    logic [31:0] line_rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [1:0]  fill_way;
    logic [5:0]  fill_index;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [21:0] tag_value;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_words [4];
    logic [31:0] wb_words [4];
    int          ack_delay = 0;
    logic        spur_ack = 1'b0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_index   (miss_index),
        .miss_tag     (miss_tag),
        .replaced_way (replaced_way),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .line_rd_en   (line_rd_en),
        .line_rd_word (line_rd_word),
        .line_rd_data (line_rd_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .fill_index   (fill_index),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .tag_we       (tag_we),
        .tag_value    (tag_value),
        .busy         (busy),
        .done         (done)
    );

    // Memory: acks after ack_delay wait cycles; spur_ack injects a stray ack.
    assign mem_ack   = spur_ack | (mem_req & (wait_cnt >= ack_delay));
    assign mem_rdata = rd_words[mem_addr[3:2]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
        if (line_rd_en) line_rd_data <= wb_words[line_rd_word];
    end

    logic [169:0] all_out;
    assign all_out = {line_rd_en, line_rd_word, mem_req, mem_we, mem_addr, mem_wdata,
                      fill_we, fill_way, fill_index, fill_word, fill_data,
                      tag_we, tag_value, busy, done};

    function automatic logic [31:0] exp_addr(input logic [21:0] t, input logic [5:0] i, input int w);
        logic [1:0] wsel;
        wsel = w[1:0];
        return {t, i, wsel, 2'b00};
    endfunction

    task automatic drive_miss(input logic [5:0] idx, input logic [21:0] tag, input logic [2:0] way,
                              input logic vd, input logic [21:0] vtag);
        miss_req     = 1'b1;
        miss_index   = idx;
        miss_tag     = tag;
        replaced_way = way;
        victim_dirty = vd;
        victim_tag   = vtag;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: outputs=%h expected 0", all_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_first_idle: outputs=%h expected 0", all_out);
        end
    endtask

    task automatic test_clean_miss();
        for (int i = 0; i < 4; i++) rd_words[i] = 32'hA0 + 32'(i);
        drive_miss(6'd5, 22'h1234, 3'd2, 1'b0, 22'h3FF);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_accept_busy: busy=%b expected 0", busy);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                vectors++;
                if (fill_we !== 1'b1 || fill_way !== 2'd2 || fill_index !== 6'd5 ||
                    fill_word !== 2'(c - 1) || fill_data !== 32'hA0 + 32'(c - 1)) begin
                    miscompares++;
                    $display("FAIL clean_fill c%0d: we=%b way=%0d idx=%0d word=%0d data=%h expected 1/2/5/%0d/%h",
                             c, fill_we, fill_way, fill_index, fill_word, fill_data, c - 1, 32'hA0 + 32'(c - 1));
                end
                vectors++;
                if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr(22'h1234, 6'd5, c - 1)) begin
                    miscompares++;
                    $display("FAIL clean_rd c%0d: req=%b we=%b addr=%h expected 1/0/%h",
                             c, mem_req, mem_we, mem_addr, exp_addr(22'h1234, 6'd5, c - 1));
                end
            end else if (c == 5) begin
                vectors++;
                if (tag_we !== 1'b1 || done !== 1'b1 || tag_value !== 22'h1234 || fill_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clean_tag: tag_we=%b done=%b tag=%h fill_we=%b expected 1/1/1234/0",
                             tag_we, done, tag_value, fill_we);
                end
                miss_req = 1'b0;
            end else begin
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clean_idle: busy=%b done=%b expected 0/0", busy, done);
                end
            end
        end
    endtask

    task automatic test_dirty_miss();
        int wr_n = 0;
        int rd_n = 0;
        int fill_n = 0;
        int done_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            wb_words[i] = 32'hB0 + 32'(i);
            rd_words[i] = 32'hD0 + 32'(i);
        end
        drive_miss(6'd9, 22'h0500, 3'd1, 1'b1, 22'h0077);
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            vectors++;
            if (line_rd_en && mem_req) begin
                miscompares++;
                $display("FAIL dirty_excl c%0d: line_rd_en and mem_req both 1", c);
            end
            if (mem_req && mem_we) begin
                vectors++;
                if (mem_addr !== exp_addr(22'h0077, 6'd9, wr_n) || mem_wdata !== 32'hB0 + 32'(wr_n)) begin
                    miscompares++;
                    $display("FAIL dirty_wr%0d: addr=%h data=%h expected %h/%h", wr_n, mem_addr, mem_wdata,
                             exp_addr(22'h0077, 6'd9, wr_n), 32'hB0 + 32'(wr_n));
                end
                if (mem_ack) wr_n++;
            end
            if (mem_req && !mem_we) begin
                vectors++;
                if (mem_addr !== exp_addr(22'h0500, 6'd9, rd_n) || wr_n != 4) begin
                    miscompares++;
                    $display("FAIL dirty_rd%0d: addr=%h writes_done=%0d expected %h/4", rd_n, mem_addr, wr_n,
                             exp_addr(22'h0500, 6'd9, rd_n));
                end
                if (mem_ack) rd_n++;
            end
            if (fill_we) begin
                vectors++;
                if (fill_word !== 2'(fill_n) || fill_data !== 32'hD0 + 32'(fill_n) || fill_way !== 2'd1) begin
                    miscompares++;
                    $display("FAIL dirty_fill%0d: word=%0d data=%h way=%0d expected %0d/%h/1",
                             fill_n, fill_word, fill_data, fill_way, fill_n, 32'hD0 + 32'(fill_n));
                end
                fill_n++;
            end
            if (done) done_cyc = c;
        end
        miss_req = 1'b0;
        vectors++;
        if (done_cyc != 17 || wr_n != 4 || rd_n != 4 || fill_n != 4) begin
            miscompares++;
            $display("FAIL dirty_summary: done_cycle=%0d writes=%0d reads=%0d fills=%0d expected 17/4/4/4",
                     done_cyc, wr_n, rd_n, fill_n);
        end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        int wr_n = 0;
        int rd_n = 0;
        int fill_n = 0;
        int done_cyc = -1;
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            wb_words[i] = 32'hE0 + 32'(i);
            rd_words[i] = 32'hF0 + 32'(i);
        end
        drive_miss(6'd33, 22'h2BEEF, 3'd3, 1'b1, 22'h01234);
        for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                vectors++;
                if (mem_addr !== exp_addr(22'h01234, 6'd33, wr_n) || mem_wdata !== 32'hE0 + 32'(wr_n)) begin
                    miscompares++;
                    $display("FAIL wait_wr%0d c%0d: addr=%h data=%h expected %h/%h", wr_n, c, mem_addr, mem_wdata,
                             exp_addr(22'h01234, 6'd33, wr_n), 32'hE0 + 32'(wr_n));
                end
                if (mem_ack) wr_n++;
            end
            if (mem_req && !mem_we) begin
                vectors++;
                if (mem_addr !== exp_addr(22'h2BEEF, 6'd33, rd_n) || wr_n != 4) begin
                    miscompares++;
                    $display("FAIL wait_rd%0d c%0d: addr=%h writes_done=%0d expected %h/4", rd_n, c, mem_addr, wr_n,
                             exp_addr(22'h2BEEF, 6'd33, rd_n));
                end
            end
            if (fill_we) begin
                vectors++;
                if (!mem_ack || fill_word !== 2'(fill_n) || fill_data !== 32'hF0 + 32'(fill_n)) begin
                    miscompares++;
                    $display("FAIL wait_fill%0d c%0d: ack=%b word=%0d data=%h expected 1/%0d/%h",
                             fill_n, c, mem_ack, fill_word, fill_data, fill_n, 32'hF0 + 32'(fill_n));
                end
                fill_n++;
            end
            if (mem_req && !mem_we && mem_ack) rd_n++;
            if (done) begin
                done_cyc = c;
                vectors++;
                if (rd_n != 4 || tag_value !== 22'h2BEEF) begin
                    miscompares++;
                    $display("FAIL wait_done: acks=%0d tag=%h expected 4/2beef", rd_n, tag_value);
                end
            end
        end
        miss_req = 1'b0;
        // 4 x (rd + wait + 4-cycle write) = 24, 4 x 4-cycle reads = 16, tag cycle 41.
        vectors++;
        if (done_cyc != 41 || wr_n != 4 || fill_n != 4) begin
            miscompares++;
            $display("FAIL wait_summary: done_cycle=%0d writes=%0d fills=%0d expected 41/4/4", done_cyc, wr_n, fill_n);
        end
        ack_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_no_replace();
        drive_miss(6'd2, 22'h00F0, 3'd4, 1'b1, 22'h0011);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || fill_we !== 1'b0 || tag_we !== 1'b0) begin
                miscompares++;
                $display("FAIL no_replace c%0d: busy=%b req=%b fill_we=%b tag_we=%b expected 0/0/0/0",
                         c, busy, mem_req, fill_we, tag_we);
            end
        end
        miss_req = 1'b0;
        victim_dirty = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int fill_n = 0;
        int done_cyc = -1;
        for (int i = 0; i < 4; i++) rd_words[i] = 32'hC0 + 32'(i);
        @(negedge clk);
        drive_miss(6'd3, 22'h2AAAA, 3'd1, 1'b0, 22'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (fill_we !== 1'b1 || fill_word !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_pre: fill_we=%b word=%0d expected 1/2", fill_we, fill_word);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL rst_async: outputs=%h expected 0", all_out);
        end
        miss_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL rst_release_idle: outputs=%h expected 0", all_out);
        end
        drive_miss(6'd3, 22'h2AAAA, 3'd1, 1'b0, 22'h0);
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (fill_word !== 2'd0 || fill_data !== 32'hC0 || mem_addr !== exp_addr(22'h2AAAA, 6'd3, 0)) begin
                    miscompares++;
                    $display("FAIL rst_restart: word=%0d data=%h addr=%h expected 0/c0/%h",
                             fill_word, fill_data, mem_addr, exp_addr(22'h2AAAA, 6'd3, 0));
                end
            end
            if (fill_we) fill_n++;
            if (done) done_cyc = c;
        end
        miss_req = 1'b0;
        vectors++;
        if (done_cyc != 5 || fill_n != 4) begin
            miscompares++;
            $display("FAIL rst_restart_done: done_cycle=%0d fills=%0d expected 5/4", done_cyc, fill_n);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        int fill_n = 0;
        int done_cyc = -1;
        spur_ack = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || fill_we !== 1'b0 || tag_we !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL spur_idle c%0d: busy=%b fill_we=%b tag_we=%b req=%b expected 0/0/0/0",
                         c, busy, fill_we, tag_we, mem_req);
            end
        end
        spur_ack = 1'b0;
        for (int i = 0; i < 4; i++) rd_words[i] = 32'h5A0 + 32'(i);
        drive_miss(6'd7, 22'h00ABC, 3'd3, 1'b0, 22'h0);
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 2) drive_miss(6'd1, 22'h3FFFF, 3'd0, 1'b1, 22'h1);
            if (fill_we) begin
                vectors++;
                if (fill_index !== 6'd7 || fill_way !== 2'd3 || fill_data !== 32'h5A0 + 32'(fill_n)) begin
                    miscompares++;
                    $display("FAIL spur_fill%0d: idx=%0d way=%0d data=%h expected 7/3/%h",
                             fill_n, fill_index, fill_way, fill_data, 32'h5A0 + 32'(fill_n));
                end
                fill_n++;
            end
            if (done) begin
                done_cyc = c;
                vectors++;
                if (tag_value !== 22'h00ABC) begin
                    miscompares++;
                    $display("FAIL spur_tag: tag=%h expected 000abc", tag_value);
                end
            end
        end
        miss_req = 1'b0;
        victim_dirty = 1'b0;
        vectors++;
        if (done_cyc != 5 || fill_n != 4) begin
            miscompares++;
            $display("FAIL spur_done: done_cycle=%0d fills=%0d expected 5/4", done_cyc, fill_n);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_after: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd_words[i] = '0;
            wb_words[i] = '0;
        end
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_no_replace();
        test_reset_mid_fill();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
